decodificador_siete_segmentos: RTL
==================================

# decodificador_siete_segmentos

Receive-side counterpart of the six-digit binary seven-segment display driver. The block samples a time-multiplexed seven-segment bus one digit per strobe, decodes each active-low pattern back to a bit, and reassembles the 6-bit counter value. Only a complete, in-order, error-free frame updates the output. It sits between a display-bus tap (loopback/self-check of the display path) and any logic that consumes the counter value.

## Interface
- TIMEOUT, default 255: maximum idle cycles allowed between strobes inside a frame. Range 1..255; 0 disables the timeout.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- entradaSegmentos  in  7  active-low segment pattern, bit 6 = segment g … bit 0 = segment a.
- entradaDigito  in  3  index of the digit being presented, 0..5 (0 = LSB).
- entradaValida  in  1  strobe; the pattern and index are sampled on edges where this is 1.
- salidaContador  out  6  last successfully decoded frame.
- salidaValida  out  1  one-cycle pulse: salidaContador just updated.
- salidaError  out  1  one-cycle pulse: current frame aborted.
- codigoError  out  2  cause of the last abort: 01 bad pattern, 10 sequence, 11 timeout. Holds until the next abort.
- contadorErrores  out  8  saturating count of aborts (stops at 255).

## Operation
- Pattern decode: 7'b1000000 → 0; 7'b1111001 → 1; any other value is a bad pattern.
- FSM states:
  - ESPERA: no frame open.
  - CAPTURA: frame open; digit n expected, n = 1..5.
- ESPERA, strobe with digit 0 and a good pattern:
  - store the bit in shadow[0];
  - set n = 1 and enter CAPTURA.
- ESPERA, strobe with any other index: ignored. No error is raised, so the block can synchronise to a free-running bus.
- ESPERA, strobe with digit 0 and a bad pattern:
  - abort with code 01;
  - stay in ESPERA.
- CAPTURA, strobe with digit n and a good pattern:
  - store the bit in shadow[n];
  - if n = 5: load salidaContador with the full shadow value, pulse salidaValida, return to ESPERA;
  - otherwise: n increments.
- CAPTURA, strobe with a bad pattern (index irrelevant): abort with code 01, go to ESPERA.
- CAPTURA, strobe with index ≠ n and a good pattern: abort with code 10.
  - If that index is 0: the strobe also opens a new frame (shadow[0] stored, n = 1, stay in CAPTURA).
  - Otherwise: go to ESPERA.
- Index 6 or 7: treated as a sequence error in CAPTURA and ignored in ESPERA.
- Timeout: in CAPTURA, an idle counter clears on every strobe and increments on every other cycle. When it reaches TIMEOUT: abort with code 11 and go to ESPERA.
- Every abort:
  - pulses salidaError and updates codigoError;
  - increments contadorErrores (saturating);
  - leaves salidaContador unchanged.
- Partial frames never alter salidaContador.

## Timing
- Reset values: salidaContador = 0, salidaValida = 0, salidaError = 0, codigoError = 00, contadorErrores = 0. FSM in ESPERA, n = 0, idle counter = 0, shadow = 0.
- Reset takes priority over every input on the same edge. Reset mid-frame discards the partial frame and raises no error.
- Latency: the digit-5 strobe sampled at edge k makes salidaContador and salidaValida = 1 visible after edge k. The pulse clears after edge k+1 unless another frame completes.
- Error pulse: same edge as the offending strobe or the timeout.
- salidaValida and salidaError are never both 1 in the same cycle.
- Strobes may arrive back to back, one per cycle. The fastest frame is 6 cycles, and one frame can complete per 6 cycles.
- Strobe coinciding with timeout expiry: the strobe wins. It is processed normally, the idle counter clears, and no timeout is raised.
- Back-to-back frames: a digit-0 strobe on the cycle after completion opens the next frame. There is no dead cycle.

## Test plan
- Reset, then strobe digits 0..5 on consecutive cycles with patterns 1,0,1,0,0,1 (1111001/1000000) → salidaContador = 6'b100101, one salidaValida pulse on the edge after digit 5, no error.
- Digits 0,1,2, then digit 4 → salidaError pulse, codigoError = 10, contadorErrores = 1, salidaContador unchanged. Then a full frame of all 1s → salidaContador = 6'b111111.
- Digit 3 carries 7'b0100100 → salidaError pulse with code 01, return to ESPERA. Following strobes of digits 4 and 5 are ignored with no further errors.
- TIMEOUT = 4: digits 0,1, then 4 idle cycles → salidaError with code 11. Repeat with a strobe on the 4th idle cycle → no timeout.
- Mid-frame sequence error where the offending index is 0, followed by digits 1..5 → exactly one error pulse, then one valid frame.
- 300 forced aborts → contadorErrores saturates at 255. Assert rst mid-frame → all outputs return to reset values and no error pulse occurs.

Source files
------------

// File: rtl/decodificador_siete_segmentos.sv
// Receive side of the six-digit binary seven-segment bus: decodes one digit per
// strobe and publishes the 6-bit value only when a complete, in-order frame arrives.
module decodificador_siete_segmentos #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] entradaSegmentos,
    input  logic [2:0] entradaDigito,
    input  logic       entradaValida,
    output logic [5:0] salidaContador,
    output logic       salidaValida,
    output logic       salidaError,
    output logic [1:0] codigoError,
    output logic [7:0] contadorErrores
);

    typedef enum logic {
        ESPERA,
        CAPTURA
    } estado_t;

    localparam logic [6:0] PATRON_CERO = 7'b1000000;
    localparam logic [6:0] PATRON_UNO  = 7'b1111001;
    localparam logic [8:0] LIMITE      = 9'(TIMEOUT);

    localparam logic [1:0] COD_PATRON    = 2'b01;
    localparam logic [1:0] COD_SECUENCIA = 2'b10;
    localparam logic [1:0] COD_TIEMPO    = 2'b11;

    estado_t     estado_q, estado_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  inactivo_q, inactivo_d;
    logic [5:0]  sombra_q, sombra_d;
    logic [5:0]  salida_q, salida_d;
    logic        valida_q, valida_d;
    logic        error_q, error_d;
    logic [1:0]  codigo_q, codigo_d;
    logic [7:0]  errores_q, errores_d;

    logic        patron_ok;
    logic        bit_dec;
    logic        aborto;
    logic [1:0]  causa;
    logic        completo;

    assign patron_ok = (entradaSegmentos == PATRON_CERO) || (entradaSegmentos == PATRON_UNO);
    assign bit_dec   = (entradaSegmentos == PATRON_UNO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= ESPERA;
            n_q        <= '0;
            inactivo_q <= '0;
            sombra_q   <= '0;
            salida_q   <= '0;
            valida_q   <= 1'b0;
            error_q    <= 1'b0;
            codigo_q   <= '0;
            errores_q  <= '0;
        end else begin
            estado_q   <= estado_d;
            n_q        <= n_d;
            inactivo_q <= inactivo_d;
            sombra_q   <= sombra_d;
            salida_q   <= salida_d;
            valida_q   <= valida_d;
            error_q    <= error_d;
            codigo_q   <= codigo_d;
            errores_q  <= errores_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        n_d        = n_q;
        inactivo_d = inactivo_q;
        sombra_d   = sombra_q;
        aborto     = 1'b0;
        causa      = 2'b00;
        completo   = 1'b0;

        unique case (estado_q)
            ESPERA: begin
                inactivo_d = '0;
                // Non-zero indices are ignored so the block can lock onto a free-running bus.
                if (entradaValida && entradaDigito == 3'd0) begin
                    if (patron_ok) begin
                        sombra_d = {5'b0, bit_dec};
                        n_d      = 3'd1;
                        estado_d = CAPTURA;
                    end else begin
                        aborto = 1'b1;
                        causa  = COD_PATRON;
                    end
                end
            end
            CAPTURA: begin
                if (entradaValida) begin
                    inactivo_d = '0;
                    if (!patron_ok) begin
                        aborto   = 1'b1;
                        causa    = COD_PATRON;
                        n_d      = '0;
                        estado_d = ESPERA;
                    end else if (entradaDigito == n_q) begin
                        sombra_d[n_q] = bit_dec;
                        if (n_q == 3'd5) begin
                            completo = 1'b1;
                            n_d      = '0;
                            estado_d = ESPERA;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        aborto = 1'b1;
                        causa  = COD_SECUENCIA;
                        // An out-of-order digit 0 doubles as the start of a fresh frame.
                        if (entradaDigito == 3'd0) begin
                            sombra_d = {5'b0, bit_dec};
                            n_d      = 3'd1;
                        end else begin
                            n_d      = '0;
                            estado_d = ESPERA;
                        end
                    end
                end else if (LIMITE != 9'd0) begin
                    if ({1'b0, inactivo_q} + 9'd1 >= LIMITE) begin
                        aborto     = 1'b1;
                        causa      = COD_TIEMPO;
                        inactivo_d = '0;
                        n_d        = '0;
                        estado_d   = ESPERA;
                    end else begin
                        inactivo_d = inactivo_q + 8'd1;
                    end
                end
            end
            default: begin
                n_d      = '0;
                estado_d = ESPERA;
            end
        endcase
    end

    always_comb begin
        salida_d  = completo ? sombra_d : salida_q;
        valida_d  = completo;
        error_d   = aborto;
        codigo_d  = aborto ? causa : codigo_q;
        errores_d = errores_q;
        if (aborto && errores_q != 8'hFF) begin
            errores_d = errores_q + 8'd1;
        end
    end

    assign salidaContador  = salida_q;
    assign salidaValida    = valida_q;
    assign salidaError     = error_q;
    assign codigoError     = codigo_q;
    assign contadorErrores = errores_q;

endmodule
